// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with start/busy/done handshake,
// optional two's-complement mode and divide-by-zero reporting.
module seq_divider #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend, then quotient shift register
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor (magnitude after PREP)
    logic [WIDTH:0]   rem_q, rem_d;     // partial remainder
    logic             sgn_q, sgn_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH+1:0] diff;             // trial subtraction; MSB is the borrow

    // Next-state, datapath and output-register computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff    = {rem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sgn_d   = SIGNED_EN && signed_op;
                    zero_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (dvs_q == '0) begin
                    // Skip iteration; the result is published one cycle later
                    zero_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIX;
                end else begin
                    if (sgn_q && dvd_q[WIDTH-1]) dvd_d = -dvd_q;
                    if (sgn_q && dvs_q[WIDTH-1]) dvs_d = -dvs_q;
                    q_neg_d = sgn_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg_d = sgn_q && dvd_q[WIDTH-1];
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (!diff[WIDTH+1]) begin
                    rem_d = diff[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (zero_q) begin
                    quo_d = '1;
                    rmd_d = dvd_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = q_neg_q ? -dvd_q : dvd_q;
                    rmd_d = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    dbz_d = 1'b0;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous clear
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule
